fetch_unit: RTL

Parametrised instruction-fetch stage that replaces the single-step PC incrementer. It owns the PC register and drives a combinational-read instruction memory. It assembles one- or two-word instructions (a long instruction carries a trailing immediate word) and presents them to decode through a valid/ready output register. It supports stall via backpressure, a fetch-enable halt, and branch/jump redirect with flush.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: fetch control, instruction-memory read port and the
// valid/ready output register toward decode.
interface fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 16
);
  logic               fetch_en;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [INSTR_W-1:0] out_imm;
  logic               out_long;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_next;

  // Fetch unit side
  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_imm, out_long, out_pc, out_pc_next
  );

  // Environment side (control, memory, decode)
  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_imm, out_long, out_pc, out_pc_next
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction
// memory, assembles short (one-word) and long (opcode + immediate) instructions
// and hands them to decode through a valid/ready output register.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                LONG_BIT = 15
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  logic [ADDR_W-1:0]  r_pc;
  logic [0:0]         r_state;
  logic [INSTR_W-1:0] r_hold_word;
  logic [ADDR_W-1:0]  r_first_pc;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [INSTR_W-1:0] r_out_imm;
  logic               r_out_long;
  logic [ADDR_W-1:0]  r_out_pc;
  logic [ADDR_W-1:0]  r_out_pc_next;

  logic               w_can_load;
  logic               w_accepted;
  logic [ADDR_W-1:0]  w_pc_inc;

  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_accepted = r_out_valid && bus.out_ready;
  assign w_pc_inc   = r_pc + ADDR_W'(1);

  assign bus.imem_addr   = r_pc;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_imm     = r_out_imm;
  assign bus.out_long    = r_out_long;
  assign bus.out_pc      = r_out_pc;
  assign bus.out_pc_next = r_out_pc_next;

  // PC, assembly state and output register: redirect beats load beats hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_state       <= ST_FIRST;
      r_hold_word   <= '0;
      r_first_pc    <= '0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_imm     <= '0;
      r_out_long    <= 1'b0;
      r_out_pc      <= '0;
      r_out_pc_next <= '0;
    end else if (bus.redirect_valid) begin
      // Pending output and any half-assembled long instruction are dropped
      r_pc        <= bus.redirect_pc;
      r_state     <= ST_FIRST;
      r_hold_word <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.fetch_en && w_can_load) begin
      if (r_state == ST_FIRST) begin
        if (!bus.imem_rdata[LONG_BIT]) begin
          r_out_instr   <= bus.imem_rdata;
          r_out_imm     <= '0;
          r_out_long    <= 1'b0;
          r_out_pc      <= r_pc;
          r_out_pc_next <= w_pc_inc;
          r_out_valid   <= 1'b1;
        end else begin
          // Opcode word of a long instruction: park it, fetch the immediate next
          r_hold_word <= bus.imem_rdata;
          r_first_pc  <= r_pc;
          r_state     <= ST_SECOND;
          r_out_valid <= 1'b0;
        end
        r_pc <= w_pc_inc;
      end else begin
        r_out_instr   <= r_hold_word;
        r_out_imm     <= bus.imem_rdata;
        r_out_long    <= 1'b1;
        r_out_pc      <= r_first_pc;
        r_out_pc_next <= r_first_pc + ADDR_W'(2);
        r_out_valid   <= 1'b1;
        r_pc          <= w_pc_inc;
        r_state       <= ST_FIRST;
      end
    end else if (w_accepted) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
